// File: rtl/div_hilo_ctrl.sv
// Sequencer around an external combinational 32-bit divider that produces HI (remainder) and LO (quotient).
// Optional macro DIV_ZERO_TRAP_EN: a zero divisor completes at once and leaves hi/lo untouched.
module div_hilo_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    input  logic [63:0] div_z,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            neg_q;
    logic            neg_r;
    logic            skip_wr;

    logic [W-1:0]    abs_a;
    logic [W-1:0]    abs_b;
    logic [W-1:0]    q_fix;
    logic [W-1:0]    r_fix;
    logic            b_zero;

    // Magnitudes wrap modulo 2^32, so |0x80000000| stays 0x80000000.
    always_comb begin
        abs_a  = (is_signed && a_in[W-1]) ? W'(~a_in + W'(1)) : a_in;
        abs_b  = (is_signed && b_in[W-1]) ? W'(~b_in + W'(1)) : b_in;
        b_zero = (b_in == '0);
        q_fix  = neg_q ? W'(~div_z[63:32] + W'(1)) : div_z[63:32];
        r_fix  = neg_r ? W'(~div_z[31:0] + W'(1))  : div_z[31:0];
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state        <= IDLE;
            cnt          <= '0;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
            skip_wr      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            div_by_zero  <= 1'b0;
            hi           <= '0;
            lo           <= '0;
            div_dividend <= '0;
            div_divisor  <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        div_dividend <= abs_a;
                        div_divisor  <= abs_b;
                        neg_q        <= is_signed & (a_in[W-1] ^ b_in[W-1]);
                        neg_r        <= is_signed & a_in[W-1];
                        div_by_zero  <= b_zero;
                        cnt          <= CW'(SETTLE_CYCLES);
                        busy         <= 1'b1;
`ifdef DIV_ZERO_TRAP_EN
                        skip_wr      <= b_zero;
                        state        <= b_zero ? CAPTURE : SETTLE;
`else
                        skip_wr      <= 1'b0;
                        state        <= SETTLE;
`endif
                    end
                end
                SETTLE: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (!skip_wr) begin
                        lo <= q_fix;
                        hi <= r_fix;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_hilo_ctrl.sv
// Directed bench for div_hilo_ctrl with a behavioural divider on div_z; honours DIV_ZERO_TRAP_EN.
module tb_div_hilo_ctrl;

    localparam int LAT = 5;   // default SETTLE_CYCLES=4 -> done observed 5 edges after accept

    logic        clock = 1'b0;
    logic        clear;
    logic        start;
    logic        is_signed;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic [63:0] div_z;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    div_hilo_ctrl dut (
        .clock        (clock),
        .clear        (clear),
        .start        (start),
        .is_signed    (is_signed),
        .a_in         (a_in),
        .b_in         (b_in),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_z        (div_z),
        .busy         (busy),
        .done         (done),
        .div_by_zero  (div_by_zero),
        .hi           (hi),
        .lo           (lo)
    );

    always #5 clock = ~clock;

    // Conforming unsigned divider: x/0 gives quotient all-ones, remainder x.
    always_comb begin
        if (div_divisor == 32'd0)
            div_z = {32'hFFFF_FFFF, div_dividend};
        else
            div_z = {div_dividend / div_divisor, div_dividend % div_divisor};
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one start and return the number of edges until done is seen (0 if never).
    task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b, output int lat);
        is_signed = s;
        a_in      = a;
        b_in      = b;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        lat       = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int ndone;

        clear     = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        a_in      = '0;
        b_in      = '0;
        tick();
        tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_dbz", 64'(div_by_zero), 64'd0);
        check("rst_ops", {div_dividend, div_divisor}, 64'd0);
        clear = 1'b0;
        tick();

        // Unsigned 100/7 with cycle-by-cycle busy/done trace
        is_signed = 1'b0;
        a_in      = 32'd100;
        b_in      = 32'd7;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        check("u_ops", {div_dividend, div_divisor}, {32'd100, 32'd7});
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("u_busy_e%0d", k), {62'd0, busy, done}, 64'b10);
        end
        tick();
        check("u_done_e5", {62'd0, busy, done}, 64'b01);
        check("u_lo", 64'(lo), 64'd14);
        check("u_hi", 64'(hi), 64'd2);
        check("u_dbz", 64'(div_by_zero), 64'd0);
        tick();
        check("u_done_drop", 64'(done), 64'd0);
        check("u_hold", {hi, lo}, {32'd2, 32'd14});

        // Signed -100/7
        do_op(1'b1, 32'hFFFF_FF9C, 32'd7, lat);
        check("s1_lat", 64'(lat), 64'(LAT));
        check("s1_ops", {div_dividend, div_divisor}, {32'd100, 32'd7});
        check("s1_lo", 64'(lo), 64'h0000_0000_FFFF_FFF2);
        check("s1_hi", 64'(hi), 64'h0000_0000_FFFF_FFFE);

        // Signed 100/-7
        do_op(1'b1, 32'd100, 32'hFFFF_FFF9, lat);
        check("s2_lat", 64'(lat), 64'(LAT));
        check("s2_lo", 64'(lo), 64'h0000_0000_FFFF_FFF2);
        check("s2_hi", 64'(hi), 64'd2);

        // Signed overflow 0x80000000 / -1 wraps
        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        check("ovf_ops", {div_dividend, div_divisor}, {32'h8000_0000, 32'd1});
        check("ovf_lo", 64'(lo), 64'h0000_0000_8000_0000);
        check("ovf_hi", 64'(hi), 64'd0);
        check("ovf_dbz", 64'(div_by_zero), 64'd0);

        // Second start while busy must be ignored
        is_signed = 1'b0;
        a_in      = 32'd1000;
        b_in      = 32'd10;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        tick();
        is_signed = 1'b1;
        a_in      = 32'hFFFF_FFCE;
        b_in      = 32'd3;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        check("bz_ops_kept", {div_dividend, div_divisor}, {32'd1000, 32'd10});
        lat = 0;
        for (int i = 3; i <= 40; i++) begin
            tick();
            if (done) begin
                lat = i;
                break;
            end
        end
        check("bz_lat", 64'(lat), 64'(LAT));
        check("bz_result", {hi, lo}, {32'd0, 32'd100});
        tick();
        check("bz_no_second", {63'd0, busy}, 64'd0);

        // Divide by zero: 5/0
        do_op(1'b0, 32'd5, 32'd0, lat);
`ifdef DIV_ZERO_TRAP_EN
        check("dz_lat", 64'(lat), 64'd1);
        check("dz_hilo", {hi, lo}, {32'd0, 32'd100});
`else
        check("dz_lat", 64'(lat), 64'(LAT));
        check("dz_hilo", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
`endif
        check("dz_flag", 64'(div_by_zero), 64'd1);
        tick();
        check("dz_flag_hold", 64'(div_by_zero), 64'd1);

        // Clear two cycles after start abandons the operation
        is_signed = 1'b0;
        a_in      = 32'd100;
        b_in      = 32'd7;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        tick();
        tick();
        #1 clear = 1'b1;
        #1;
        check("clr_busy_done", {62'd0, busy, done}, 64'd0);
        check("clr_hilo", {hi, lo}, 64'd0);
        check("clr_ops", {div_dividend, div_divisor}, 64'd0);
        check("clr_dbz", 64'(div_by_zero), 64'd0);
        clear = 1'b0;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done) ndone++;
        end
        check("clr_no_done", 64'(ndone), 64'd0);
        check("clr_hilo_after", {hi, lo}, 64'd0);

        // Normal operation after clear, then a back-to-back start from the done cycle
        do_op(1'b0, 32'd100, 32'd7, lat);
        check("post_lat", 64'(lat), 64'(LAT));
        check("post_res", {hi, lo}, {32'd2, 32'd14});
        do_op(1'b0, 32'd45, 32'd6, lat);
        check("b2b_lat", 64'(lat), 64'(LAT));
        check("b2b_res", {hi, lo}, {32'd3, 32'd7});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_hilo_ctrl.md
DIV_HILO_CTRL -- requirements
Module: div_hilo_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4: clock cycles the combinational divider is given to settle; legal range 1..15.
REQ-002 SHALL have port clock, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port clear, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port start, input, 1: request a divide; accepted only when busy=0.
REQ-005 SHALL have port is_signed, input, 1: 1 = signed two's-complement divide; 0 = unsigned.
REQ-006 SHALL have port a_in, input, 32: dividend.
REQ-007 SHALL have port b_in, input, 32: divisor.
REQ-008 SHALL have port div_dividend, output, 32: registered operand driven to the divider's Dividend.
REQ-009 SHALL have port div_divisor, output, 32: registered operand driven to the divider's Divisor.
REQ-010 SHALL have port div_z, input, 64: divider result; quotient in [63:32], remainder in [31:0].
REQ-011 SHALL have port busy, output, 1: operation in progress.
REQ-012 SHALL have port done, output, 1: one-cycle pulse when hi/lo have been updated.
REQ-013 SHALL have port div_by_zero, output, 1: last accepted operation had divisor 0.
REQ-014 SHALL have port hi, output, 32: remainder register.
REQ-015 SHALL have port lo, output, 32: quotient register.

Function
REQ-016 SHALL implement states IDLE, SETTLE and CAPTURE; busy=1 exactly in SETTLE and CAPTURE.
REQ-017 SHALL, on start=1 in IDLE, latch operands: div_dividend=|a_in| and div_divisor=|b_in| when is_signed=1, raw values otherwise; latch quotient-negate flag (a_in[31]^b_in[31]) and remainder-negate flag (a_in[31]), both 0 when unsigned; load settle counter with SETTLE_CYCLES; enter SETTLE.
REQ-018 SHALL decrement the counter each cycle in SETTLE and enter CAPTURE when it reaches 1.
REQ-019 SHALL, in CAPTURE, write lo=div_z[63:32] and hi=div_z[31:0], each two's-complement negated when its flag is set, assert done for that cycle, and return to IDLE.
REQ-020 SHALL pulse done in cycle N+SETTLE_CYCLES+1 for start accepted at edge N; back-to-back start is accepted in the cycle after done.
REQ-021 SHALL ignore start while busy=1; operands and flags are not disturbed.
REQ-022 SHALL compute 32-bit magnitudes modulo 2^32, so |0x80000000| = 0x80000000.
REQ-023 SHALL produce lo=0x80000000, hi=0 for signed 0x80000000 / 0xFFFFFFFF (overflow wraps, no flag).
REQ-024 SHALL hold hi, lo, div_dividend and div_divisor stable outside CAPTURE or the accepting edge respectively.
REQ-025 SHALL keep div_by_zero at its value until the next accepted start, which updates it to (b_in==0).

Reset
REQ-026 SHALL, on clear=1 at any time including mid-operation, force state IDLE, counter 0, busy=0, done=0, div_by_zero=0, hi=0, lo=0, div_dividend=0, div_divisor=0, flags 0.
REQ-027 SHALL abandon an in-flight operation on clear with no done pulse and no hi/lo write.

Configuration
REQ-028 SHALL, when macro DIV_ZERO_TRAP_EN is defined, on accepting start with b_in==0, skip SETTLE, go directly to CAPTURE (done at N+1), leave hi and lo unchanged, and set div_by_zero=1.
REQ-029 SHALL, when DIV_ZERO_TRAP_EN is not defined, run a zero divisor through the normal path and write whatever div_z holds; div_by_zero is still reported.

Verification
REQ-030 SHALL test unsigned 100/7, SETTLE_CYCLES=4, start at edge 0 -> done at edge 5, lo=14, hi=2, busy high edges 1..4.
REQ-031 SHALL test signed -100/7 -> lo=0xFFFFFFF2 (-14), hi=0xFFFFFFFE (-2); signed 100/-7 -> lo=-14, hi=2.
REQ-032 SHALL test signed 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
REQ-033 SHALL test 5/0 with DIV_ZERO_TRAP_EN -> done one cycle after start, hi/lo unchanged, div_by_zero=1; without the macro -> done at normal latency, lo=0xFFFFFFFF, hi=5 from a conforming divider, div_by_zero=1.
REQ-034 SHALL test clear pulsed two cycles after start -> no done, all outputs 0, next start completes normally.
REQ-035 SHALL test second start while busy with different operands -> ignored, first result delivered unchanged.
